// File: rtl/pkg_pipeline.sv
// Shared pipeline definitions: register-address width,
// forwarding select encodings and hazard tracking entries.
package pkg_pipeline;

    localparam int REG_ADDR_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  writes;
        logic                  load;
    } entrada_t;

    // An entry produces a value only if it is real, writes and is not r0.
    function automatic logic produtor(input entrada_t e);
        return e.valid && e.writes && (e.rd != '0);
    endfunction

endpackage

// File: rtl/detecta_dependencia.sv
// Per-operand dependency check against the EX and MEM entries:
// yields the forwarding select and a load-use hit flag.
module detecta_dependencia
    import pkg_pipeline::*;
(
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  entrada_t              ex_i,
    input  entrada_t              mem_i,
    output logic [1:0]            sel_o,
    output logic                  load_hit_o
);

    logic hit_ex;
    logic hit_mem;

    assign hit_ex  = produtor(ex_i) && (ex_i.rd == rs_i);
    assign hit_mem = produtor(mem_i) && (mem_i.rd == rs_i);

    // Youngest producer wins; a load in EX cannot be forwarded yet.
    always_comb begin
        sel_o      = FWD_REG;
        load_hit_o = hit_ex && ex_i.load;
        if (hit_ex && !ex_i.load) begin
            sel_o = FWD_ALU;
        end else if (hit_mem) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/unidade_forwarding.sv
// Forwarding select generation and load-use stall control
// for the ID->EX boundary of the 5-stage pipeline.
module unidade_forwarding
    import pkg_pipeline::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  congela,
    input  logic                  valido_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  escreve_reg_id,
    input  logic                  le_mem_id,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  stall,
    output logic                  bolha_ex
);

    entrada_t   ex_q;
    entrada_t   ex_d;
    entrada_t   mem_q;
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_q;
    logic [1:0] fwd_b_d;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_hit_a;
    logic       load_hit_b;

    detecta_dependencia u_dep_a (
        .rs_i       (rs1_id),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (sel_a),
        .load_hit_o (load_hit_a)
    );

    detecta_dependencia u_dep_b (
        .rs_i       (rs2_id),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (sel_b),
        .load_hit_o (load_hit_b)
    );

    assign stall    = valido_id && (load_hit_a || load_hit_b);
    assign bolha_ex = stall;
    assign forwardA = fwd_a_q;
    assign forwardB = fwd_b_q;

    // Next EX entry and selects; a stalled ID slot becomes a bubble.
    always_comb begin
        ex_d.valid  = valido_id && !stall;
        ex_d.rd     = rd_id;
        ex_d.writes = escreve_reg_id;
        ex_d.load   = le_mem_id;
        fwd_a_d     = FWD_REG;
        fwd_b_d     = FWD_REG;
        if (valido_id && !stall) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    // Advance tracking entries and selects unless frozen; reset wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (!congela) begin
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

endmodule

// File: tb/tb_unidade_forwarding.sv
// Directed table-driven bench for unidade_forwarding plus
// hand sequences for freeze and reset-during-stall.
module tb_unidade_forwarding;

    logic       clock;
    logic       reset;
    logic       congela;
    logic       valido_id;
    logic [3:0] rs1_id;
    logic [3:0] rs2_id;
    logic [3:0] rd_id;
    logic       escreve_reg_id;
    logic       le_mem_id;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       stall;
    logic       bolha_ex;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       v;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       e_stall;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
    } vec_t;

    vec_t tab[21];

    unidade_forwarding dut (
        .clock          (clock),
        .reset          (reset),
        .congela        (congela),
        .valido_id      (valido_id),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .rd_id          (rd_id),
        .escreve_reg_id (escreve_reg_id),
        .le_mem_id      (le_mem_id),
        .forwardA       (forwardA),
        .forwardB       (forwardB),
        .stall          (stall),
        .bolha_ex       (bolha_ex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input int rs1,
                                input int rs2, input int rd,
                                input logic wr, input logic ld,
                                input logic es, input logic [1:0] fa,
                                input logic [1:0] fb);
        vec_t t;
        t.v = v;
        t.rs1 = rs1[3:0];
        t.rs2 = rs2[3:0];
        t.rd = rd[3:0];
        t.wr = wr;
        t.ld = ld;
        t.e_stall = es;
        t.e_fa = fa;
        t.e_fb = fb;
        return t;
    endfunction

    task automatic drive(input logic v, input int rs1, input int rs2,
                         input int rd, input logic wr, input logic ld);
        valido_id = v;
        rs1_id = rs1[3:0];
        rs2_id = rs2[3:0];
        rd_id = rd[3:0];
        escreve_reg_id = wr;
        le_mem_id = ld;
    endtask

    task automatic chk_stall(input string nm, input logic exp);
        chk({nm, ".stall"}, {1'b0, stall}, {1'b0, exp});
        chk({nm, ".bolha"}, {1'b0, bolha_ex}, {1'b0, exp});
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        congela = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);

        tab[0]  = mk(1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00);
        tab[1]  = mk(1, 3, 7, 6, 1, 0, 0, 2'b10, 2'b00);
        tab[2]  = mk(1, 8, 9, 5, 1, 0, 0, 2'b00, 2'b00);
        tab[3]  = mk(1, 10, 11, 12, 1, 0, 0, 2'b00, 2'b00);
        tab[4]  = mk(1, 1, 5, 13, 1, 0, 0, 2'b00, 2'b01);
        tab[5]  = mk(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00);
        tab[6]  = mk(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00);
        tab[7]  = mk(1, 5, 5, 14, 1, 0, 0, 2'b10, 2'b10);
        tab[8]  = mk(1, 2, 0, 4, 1, 1, 0, 2'b00, 2'b00);
        tab[9]  = mk(1, 4, 14, 4, 1, 0, 1, 2'b00, 2'b00);
        tab[10] = mk(1, 4, 14, 4, 1, 0, 0, 2'b01, 2'b00);
        tab[11] = mk(1, 9, 4, 9, 0, 0, 0, 2'b00, 2'b10);
        tab[12] = mk(1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        tab[13] = mk(1, 0, 9, 2, 1, 0, 0, 2'b00, 2'b00);
        tab[14] = mk(1, 2, 3, 0, 1, 1, 0, 2'b10, 2'b00);
        tab[15] = mk(1, 0, 0, 8, 1, 0, 0, 2'b00, 2'b00);
        tab[16] = mk(0, 8, 8, 8, 1, 0, 0, 2'b00, 2'b00);
        tab[17] = mk(1, 8, 1, 0, 0, 0, 0, 2'b01, 2'b00);
        tab[18] = mk(1, 1, 2, 10, 1, 1, 0, 2'b00, 2'b00);
        tab[19] = mk(1, 3, 10, 11, 1, 0, 1, 2'b00, 2'b00);
        tab[20] = mk(1, 3, 10, 11, 1, 0, 0, 2'b00, 2'b01);

        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("reset.fa", forwardA, 2'b00);
        chk("reset.fb", forwardB, 2'b00);
        chk_stall("reset", 1'b0);

        for (int i = 0; i < 21; i++) begin
            drive(tab[i].v, tab[i].rs1, tab[i].rs2, tab[i].rd,
                  tab[i].wr, tab[i].ld);
            #1;
            chk_stall($sformatf("v%0d", i), tab[i].e_stall);
            tick;
            chk($sformatf("v%0d.fa", i), forwardA, tab[i].e_fa);
            chk($sformatf("v%0d.fb", i), forwardB, tab[i].e_fb);
        end

        // Freeze between producer add r3 and its consumer.
        drive(1'b1, 1, 2, 3, 1'b1, 1'b0);
        tick;
        chk("frz.prod.fa", forwardA, 2'b00);
        chk("frz.prod.fb", forwardB, 2'b00);
        drive(1'b1, 3, 11, 6, 1'b1, 1'b0);
        congela = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("frz%0d.fa", k), forwardA, 2'b00);
            chk($sformatf("frz%0d.fb", k), forwardB, 2'b00);
            chk_stall($sformatf("frz%0d", k), 1'b0);
        end
        congela = 1'b0;
        tick;
        chk("frz.cons.fa", forwardA, 2'b10);
        chk("frz.cons.fb", forwardB, 2'b01);

        // Load-use held under freeze, then reset (with freeze) in stall.
        drive(1'b1, 1, 2, 4, 1'b1, 1'b1);
        tick;
        drive(1'b1, 4, 4, 5, 1'b1, 1'b0);
        #1;
        chk_stall("lu", 1'b1);
        congela = 1'b1;
        tick;
        chk_stall("lu.frz", 1'b1);
        chk("lu.frz.fa", forwardA, 2'b00);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        congela = 1'b0;
        #1;
        chk_stall("rst", 1'b0);
        chk("rst.fa", forwardA, 2'b00);
        chk("rst.fb", forwardB, 2'b00);
        tick;
        chk("rst.next.fa", forwardA, 2'b00);
        chk("rst.next.fb", forwardB, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
